// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES hasher H0 words for values below a target, keeps the lowest-index hit, writes a 3-word report.
// Optional feature macro NONCE_SCAN_EARLY_EXIT_EN: stop at the first hit instead of counting every hit.
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16,
  parameter int NONCE_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [15:0]        result_addr,
  input  logic [15:0]        report_addr,
  input  logic [31:0]        target,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [31:0]        best_value,
  output logic [NONCE_W:0]   hit_count,
  output logic               mem_clk,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [31:0]        mem_write_data,
  input  logic [31:0]        mem_read_data
);

  localparam int CW = NONCE_W + 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_NONCES);
  localparam logic [CW-1:0] ISSUE_LIM = CW'(NUM_NONCES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WR0,
    WR1,
    WR2,
    FIN
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          raddr_q, raddr_d;
  logic [15:0]          waddr_q, waddr_d;
  logic [31:0]          target_q, target_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   best_nonce_q, best_nonce_d;
  logic [31:0]          best_value_q, best_value_d;
  logic [CW-1:0]        hit_count_q, hit_count_d;
  logic                 mem_we_q, mem_we_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;

  logic                 cap_vld;
  logic                 hit;
  logic [NONCE_W-1:0]   cap_idx;

  // cnt_q is edges since start minus one; read data for index cnt_q-1 is valid once cnt_q >= 1
  assign cap_vld = (cnt_q != '0);
  assign hit     = (mem_read_data < target_q);
  assign cap_idx = NONCE_W'(cnt_q - ONE);

  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    found_d      = found_q;
    best_nonce_d = best_nonce_q;
    best_value_d = best_value_q;
    hit_count_d  = hit_count_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          raddr_d      = result_addr;
          waddr_d      = report_addr;
          target_d     = target;
          cnt_d        = '0;
          done_d       = 1'b0;
          found_d      = 1'b0;
          best_nonce_d = '0;
          best_value_d = 32'hFFFF_FFFF;
          hit_count_d  = '0;
          mem_we_d     = 1'b0;
          mem_addr_d   = result_addr;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q < ISSUE_LIM) begin
          mem_addr_d = raddr_q + 16'(cnt_q) + 16'd1;
        end
`ifdef NONCE_SCAN_EARLY_EXIT_EN
        if (cap_vld && hit) begin
          // first hit wins; remaining in-flight reads are dropped
          found_d      = 1'b1;
          best_nonce_d = cap_idx;
          best_value_d = mem_read_data;
          hit_count_d  = ONE;
          mem_addr_d   = mem_addr_q;
          state_d      = WR0;
        end else if (cap_vld && (cnt_q == LAST_CNT)) begin
          state_d = WR0;
        end
`else
        if (cap_vld && hit) begin
          hit_count_d = hit_count_q + ONE;
          if (!found_q) begin
            found_d      = 1'b1;
            best_nonce_d = cap_idx;
            best_value_d = mem_read_data;
          end
        end
        if (cap_vld && (cnt_q == LAST_CNT)) begin
          state_d = WR0;
        end
`endif
      end

      WR0: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = waddr_q;
        mem_wdata_d = {found_q, {(31-NONCE_W){1'b0}}, best_nonce_q};
        state_d     = WR1;
      end

      WR1: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = waddr_q + 16'd1;
        mem_wdata_d = best_value_q;
        state_d     = WR2;
      end

      WR2: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = waddr_q + 16'd2;
        mem_wdata_d = {{(31-NONCE_W){1'b0}}, hit_count_q};
        state_d     = FIN;
      end

      FIN: begin
        mem_we_d = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      raddr_q      <= '0;
      waddr_q      <= '0;
      target_q     <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      best_nonce_q <= '0;
      best_value_q <= 32'hFFFF_FFFF;
      hit_count_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      found_q      <= found_d;
      best_nonce_q <= best_nonce_d;
      best_value_q <= best_value_d;
      hit_count_q  <= hit_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_clk        = clk;
  assign done           = done_q;
  assign found          = found_q;
  assign best_nonce     = best_nonce_q;
  assign best_value     = best_value_q;
  assign hit_count      = hit_count_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Bench for nonce_result_scanner: table of scan vectors with a result scoreboard, plus reset-in-write sequence.
`timescale 1ns/1ps
module tb_nonce_result_scanner;

  localparam int N  = 16;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   result_addr = '0;
  logic [15:0]   report_addr = '0;
  logic [31:0]   target = '0;
  logic          done, found;
  logic [NW-1:0] best_nonce;
  logic [31:0]   best_value;
  logic [NW:0]   hit_count;
  logic          mem_clk, mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  always #5 clk = ~clk;

  nonce_result_scanner #(.NUM_NONCES(N), .NONCE_W(NW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .result_addr(result_addr), .report_addr(report_addr), .target(target),
    .done(done), .found(found), .best_nonce(best_nonce), .best_value(best_value),
    .hit_count(hit_count), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Synchronous-read memory; DUT writes go to a log so the preloaded words stay intact
  typedef struct { logic [15:0] addr; logic [31:0] dat; } wr_t;
  logic [31:0] mem [65536];
  wr_t         wlog[$];

  always @(posedge mem_clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) wlog.push_back('{addr: mem_addr, dat: mem_write_data});
  end

  // Read addresses presented during a scan must stay inside the H0 window
  logic        mon_en = 1'b0;
  logic [15:0] mon_base = '0;
  int          oob_cnt = 0;
  always @(negedge clk) begin
    if (mon_en && !done && !mem_we && (16'(mem_addr - mon_base) >= 16'(N))) oob_cnt++;
  end

  typedef struct {
    int          pat;
    logic [15:0] raddr, waddr;
    logic [31:0] tgt;
    bit          mid;
    logic        fnd;
    logic [7:0]  nonce;
    logic [31:0] val;
    logic [8:0]  cnt;
  } vec_t;

  typedef struct {
    logic        fnd;
    logic [7:0]  nonce;
    logic [31:0] val;
    logic [8:0]  cnt;
    int          lat;
    logic [15:0] waddr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat_word(input int pat, input int i);
    case (pat)
      0: return 32'h1000_0000 + 32'(i);
      1: return (i == 5) ? 32'h0000_0F00 : (i == 9) ? 32'h0000_0010 : 32'hFFFF_FFFF;
      2: return 32'h0;
      default: return (i % 2 == 1) ? 32'(i) : 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic fill(input int pat, input logic [15:0] base);
    for (int i = 0; i < N; i++) mem[16'(base + 16'(i))] = pat_word(pat, i);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_found"}, 64'(found), 64'(0));
    chk({tag, "_nonce"}, 64'(best_nonce), 64'(0));
    chk({tag, "_value"}, 64'(best_value), 64'(32'hFFFF_FFFF));
    chk({tag, "_hits"}, 64'(hit_count), 64'(0));
    chk({tag, "_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_write_data), 64'(0));
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   cyc, wb, ob;
    bit   seen;
    fill(v.pat, v.raddr);
    e.fnd = v.fnd; e.nonce = v.nonce; e.val = v.val; e.waddr = v.waddr;
`ifdef NONCE_SCAN_EARLY_EXIT_EN
    e.cnt = v.fnd ? 9'd1 : 9'd0;
    e.lat = v.fnd ? int'(v.nonce) + 6 : N + 5;
`else
    e.cnt = v.cnt;
    e.lat = N + 5;
`endif
    wb = wlog.size();
    ob = oob_cnt;
    @(negedge clk);
    result_addr = v.raddr; report_addr = v.waddr; target = v.tgt; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mon_base = v.raddr; mon_en = 1'b1;
    chk("done_cleared", 64'(done), 64'(0));
    cyc = 0; seen = 0;
    while (cyc < 400 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (v.mid && cyc == 3) begin
        start = 1'b1; result_addr = 16'h1234; target = 32'h0;
      end else if (cyc == 4) begin
        start = 1'b0;
      end
      seen = done;
    end
    mon_en = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      chk("done_timeout", 64'(0), 64'(1));
      return;
    end
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("found", 64'(found), 64'(e.fnd));
    chk("best_nonce", 64'(best_nonce), 64'(e.nonce));
    chk("best_value", 64'(best_value), 64'(e.val));
    chk("hit_count", 64'(hit_count), 64'(e.cnt));
    chk("oob_reads", 64'(oob_cnt - ob), 64'(0));
    chk("report_writes", 64'(wlog.size() - wb), 64'(3));
    if (wlog.size() - wb == 3) begin
      chk("rep0_addr", 64'(wlog[wb].addr), 64'(e.waddr));
      chk("rep0_dat", 64'(wlog[wb].dat), 64'({e.fnd, 23'b0, e.nonce}));
      chk("rep1_addr", 64'(wlog[wb+1].addr), 64'(16'(e.waddr + 16'd1)));
      chk("rep1_dat", 64'(wlog[wb+1].dat), 64'(e.val));
      chk("rep2_addr", 64'(wlog[wb+2].addr), 64'(16'(e.waddr + 16'd2)));
      chk("rep2_dat", 64'(wlog[wb+2].dat), 64'({23'b0, e.cnt}));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 64'(done), 64'(1));
    chk("hold_value", 64'(best_value), 64'(e.val));
    chk("hold_hits", 64'(hit_count), 64'(e.cnt));
  endtask

  initial begin
    vec_t vt[7];
    int   wb, cyc;
    bit   seen;

    //        pat raddr     waddr     target          mid fnd nonce val            cnt
    vt[0] = '{0, 16'h0100, 16'h0200, 32'h0000_0001, 0, 0, 8'd0, 32'hFFFF_FFFF, 9'd0};
    vt[1] = '{1, 16'h0300, 16'h0400, 32'h0000_1000, 1, 1, 8'd5, 32'h0000_0F00, 9'd2};
    vt[2] = '{2, 16'h0500, 16'h0600, 32'h0000_0001, 0, 1, 8'd0, 32'h0000_0000, 9'd16};
    vt[3] = '{0, 16'h0100, 16'h0700, 32'h0000_0000, 0, 0, 8'd0, 32'hFFFF_FFFF, 9'd0};
    vt[4] = '{3, 16'h0800, 16'h0900, 32'hFFFF_FFFF, 0, 1, 8'd1, 32'h0000_0001, 9'd8};
    vt[5] = '{1, 16'hFFF8, 16'hFFFE, 32'h0000_1000, 1, 1, 8'd5, 32'h0000_0F00, 9'd2};
    vt[6] = '{0, 16'h1000, 16'h1100, 32'h1000_0008, 0, 1, 8'd0, 32'h1000_0000, 9'd8};

    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;

    #1 reset_n = 1'b0;
    #20;
    chk_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 7; k++) run(vt[k]);

    // Reset while the report is being written
    fill(2, 16'h0500);
    wb = wlog.size();
    @(negedge clk);
    result_addr = 16'h0500; report_addr = 16'h0A00; target = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; seen = 0;
    while (cyc < 100 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      seen = mem_we && (mem_addr == 16'h0A00);
    end
    chk("wr1_reached", 64'(seen), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1;
    begin
      int n2;
      n2 = 0;
      for (int j = wb; j < wlog.size(); j++) if (wlog[j].addr == 16'h0A02) n2++;
      chk("no_rep2_write", 64'(n2), 64'(0));
    end
    chk("still_idle", 64'(done), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run(vt[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
